// File: rtl/cycle_counter_bank.sv
// Bank of independent start/stop/clear cycle counters with a shared terminal count,
// optional auto-stop on hit, and wrap or saturate overflow handling.
module cycle_counter_bank #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 4,
    parameter int AUTO_STOP = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    input  logic [CHANNELS-1:0]       clear,
    input  logic [WIDTH-1:0]          limit,
    input  logic                      sat_mode,
    output logic [CHANNELS*WIDTH-1:0] res,
    output logic [CHANNELS-1:0]       running,
    output logic [CHANNELS-1:0]       hit,
    output logic [CHANNELS-1:0]       ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [CHANNELS-1:0][WIDTH-1:0] val_q, val_d;
    logic [CHANNELS-1:0]            run_q, run_d;
    logic [CHANNELS-1:0]            hit_q, hit_d;
    logic [CHANNELS-1:0]            ovf_q, ovf_d;

    always_comb begin
        val_d = val_q;
        run_d = run_q;
        hit_d = '0;
        ovf_d = ovf_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (clear[i]) begin
                val_d[i] = '0;
                run_d[i] = 1'b0;
                ovf_d[i] = 1'b0;
            end else if (stop[i]) begin
                run_d[i] = 1'b0;
            end else if (!run_q[i]) begin
                if (start[i]) begin
                    run_d[i] = 1'b1;
                end
            end else if (val_q[i] == MAX_VAL) begin
                // Wrapping lands on 0, which can never equal a nonzero limit.
                ovf_d[i] = 1'b1;
                if (!sat_mode) begin
                    val_d[i] = '0;
                end
            end else begin
                val_d[i] = val_q[i] + 1'b1;
                if ((limit != '0) && (val_d[i] == limit)) begin
                    hit_d[i] = 1'b1;
                    if (AUTO_STOP != 0) begin
                        run_d[i] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_q <= '0;
            run_q <= '0;
            hit_q <= '0;
            ovf_q <= '0;
        end else begin
            val_q <= val_d;
            run_q <= run_d;
            hit_q <= hit_d;
            ovf_q <= ovf_d;
        end
    end

    assign res     = val_q;
    assign running = run_q;
    assign hit     = hit_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_cycle_counter_bank.sv
// Testbench for cycle_counter_bank: vector table, directed corner sequences and
// randomized traffic checked against a behavioural counter model.
module tb_cycle_counter_bank;

    localparam int W = 8;
    localparam int C = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [C-1:0]     start = '0;
    logic [C-1:0]     stop = '0;
    logic [C-1:0]     clear = '0;
    logic [W-1:0]     limit = '0;
    logic             sat_mode = 1'b0;
    logic [C*W-1:0]   res;
    logic [C-1:0]     running;
    logic [C-1:0]     hit;
    logic [C-1:0]     ovf;

    int tests = 0;
    int fails = 0;

    int m_val [C];
    bit m_run [C];
    bit m_hit [C];
    bit m_ovf [C];

    typedef struct {
        logic         st, sp, cl;
        logic [W-1:0] lim;
        logic [W-1:0] eres;
        logic         erun, ehit, eovf;
    } vec_t;

    vec_t tbl [21];

    cycle_counter_bank #(.WIDTH(W), .CHANNELS(C), .AUTO_STOP(1)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .limit(limit), .sat_mode(sat_mode), .res(res), .running(running),
        .hit(hit), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int st, int sp, int cl, int lim, int eres, int erun, int ehit, int eovf);
        vec_t v;
        v.st = st[0]; v.sp = sp[0]; v.cl = cl[0];
        v.lim = W'(lim); v.eres = W'(eres);
        v.erun = erun[0]; v.ehit = ehit[0]; v.eovf = eovf[0];
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < C; i++) begin
            m_val[i] = 0; m_run[i] = 0; m_hit[i] = 0; m_ovf[i] = 0;
        end
    endfunction

    // One clock edge of the counter rules, computed on plain integers.
    function automatic void model_update();
        int top;
        top = (1 << W) - 1;
        if (!rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < C; i++) begin
            m_hit[i] = 0;
            if (clear[i]) begin
                m_val[i] = 0; m_run[i] = 0; m_ovf[i] = 0;
            end else if (stop[i]) begin
                m_run[i] = 0;
            end else if (start[i] && !m_run[i]) begin
                m_run[i] = 1;
            end else if (m_run[i]) begin
                if (m_val[i] == top) begin
                    m_ovf[i] = 1;
                    if (!sat_mode) m_val[i] = 0;
                end else begin
                    m_val[i] = m_val[i] + 1;
                    if (int'(limit) != 0 && m_val[i] == int'(limit)) begin
                        m_hit[i] = 1;
                        m_run[i] = 0;
                    end
                end
            end
        end
    endfunction

    task automatic check(string name, logic [C*W-1:0] er, logic [C-1:0] erun, logic [C-1:0] ehit, logic [C-1:0] eovf);
        tests++;
        if (res !== er || running !== erun || hit !== ehit || ovf !== eovf) begin
            fails++;
            $display("FAIL %s: got res=%h running=%b hit=%b ovf=%b, expected res=%h running=%b hit=%b ovf=%b",
                     name, res, running, hit, ovf, er, erun, ehit, eovf);
        end
    endtask

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(string name);
        logic [C*W-1:0] er;
        logic [C-1:0]   erun, ehit, eovf;
        for (int i = 0; i < C; i++) begin
            er[i*W +: W] = W'(m_val[i]);
            erun[i] = m_run[i]; ehit[i] = m_hit[i]; eovf[i] = m_ovf[i];
        end
        check(name, er, erun, ehit, eovf);
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        start = '0; stop = '0; clear = '0;
    endtask

    function automatic int field(int ch);
        return int'(res[ch*W +: W]);
    endfunction

    initial begin
        // start stop clear limit | res running hit ovf  (channel 0)
        tbl[0]  = mk(1, 0, 0, 0, 0, 1, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 1, 1, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 2, 1, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 3, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 4, 1, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 5, 1, 0, 0);
        tbl[6]  = mk(0, 1, 0, 0, 5, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 5, 0, 0, 0);
        tbl[8]  = mk(1, 0, 0, 0, 5, 1, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 6, 1, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 7, 1, 0, 0);
        tbl[11] = mk(1, 1, 1, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 0, 0, 0, 0, 1, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 1, 1, 0, 0);
        tbl[14] = mk(1, 1, 0, 0, 1, 0, 0, 0);
        tbl[15] = mk(0, 1, 0, 0, 1, 0, 0, 0);
        tbl[16] = mk(1, 0, 0, 3, 1, 1, 0, 0);
        tbl[17] = mk(0, 0, 0, 3, 2, 1, 0, 0);
        tbl[18] = mk(0, 0, 0, 3, 3, 0, 1, 0);
        tbl[19] = mk(0, 0, 0, 3, 3, 0, 0, 0);
        tbl[20] = mk(0, 0, 1, 3, 0, 0, 0, 0);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset", '0, '0, '0, '0);
        rst = 1'b1;

        for (int i = 0; i < 21; i++) begin
            idle();
            start[0] = tbl[i].st; stop[0] = tbl[i].sp; clear[0] = tbl[i].cl;
            limit = tbl[i].lim;
            step();
            check($sformatf("vec%0d", i), {{(C-1)*W{1'b0}}, tbl[i].eres},
                  {3'b000, tbl[i].erun}, {3'b000, tbl[i].ehit}, {3'b000, tbl[i].eovf});
        end

        // Auto-stop on limit 10, channel 2
        idle(); clear = '1; limit = '0; step(); idle();
        limit = 8'd10; start[2] = 1'b1; step(); idle();
        chk("autostop_running", int'(running[2]), 1);
        for (int k = 1; k < 10; k++) begin
            step();
            chk($sformatf("autostop_cnt%0d", k), field(2), k);
            chk($sformatf("autostop_nohit%0d", k), int'(hit[2]), 0);
        end
        step();
        check("autostop_hit", {8'd0, 8'd10, 8'd0, 8'd0}, 4'b0000, 4'b0100, 4'b0000);
        for (int k = 0; k < 20; k++) begin
            step();
            check($sformatf("autostop_hold%0d", k), {8'd0, 8'd10, 8'd0, 8'd0}, 4'b0000, 4'b0000, 4'b0000);
        end

        // Wrap then saturate on channel 1
        idle(); clear = '1; limit = '0; sat_mode = 1'b0; step(); idle();
        start[1] = 1'b1; step(); idle();
        repeat (255) step();
        chk("wrap_pre", field(1), 255);
        chk("wrap_pre_ovf", int'(ovf[1]), 0);
        step();
        check("wrap", '0, 4'b0010, 4'b0000, 4'b0010);
        clear[1] = 1'b1; step(); idle();
        sat_mode = 1'b1; start[1] = 1'b1; step(); idle();
        repeat (256) step();
        check("saturate", {8'd0, 8'd0, 8'd255, 8'd0}, 4'b0010, 4'b0000, 4'b0010);
        step();
        check("saturate_hold", {8'd0, 8'd0, 8'd255, 8'd0}, 4'b0010, 4'b0000, 4'b0010);
        clear[1] = 1'b1; step(); idle();
        check("sat_clear", '0, '0, '0, '0);
        sat_mode = 1'b0;

        // Asynchronous reset in the middle of a count
        start[0] = 1'b1; step(); idle();
        repeat (35) step();
        chk("pre_reset_cnt", field(0), 35);
        #3 rst = 1'b0;
        #1;
        model_reset();
        check("async_reset", '0, '0, '0, '0);
        @(negedge clk) rst = 1'b1;
        repeat (3) step();
        check("post_reset_idle", '0, '0, '0, '0);

        // Independence of channels 0 and 3
        start[0] = 1'b1; step(); idle();
        start[3] = 1'b1; step(); idle();
        check("indep_a", {8'd0, 8'd0, 8'd0, 8'd1}, 4'b1001, 4'b0000, 4'b0000);
        step(); step(); step();
        check("indep_b", {8'd3, 8'd0, 8'd0, 8'd4}, 4'b1001, 4'b0000, 4'b0000);
        clear[0] = 1'b1; step(); idle();
        check("indep_clear", {8'd4, 8'd0, 8'd0, 8'd0}, 4'b1000, 4'b0000, 4'b0000);
        step();
        check("indep_after", {8'd5, 8'd0, 8'd0, 8'd0}, 4'b1000, 4'b0000, 4'b0000);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < C; i++) begin
                start[i] = ($urandom_range(0, 7) == 0);
                stop[i]  = ($urandom_range(0, 39) == 0);
                clear[i] = ($urandom_range(0, 149) == 0);
            end
            if ($urandom_range(0, 49) == 0)
                limit = ($urandom_range(0, 3) == 0) ? 8'd0 : W'($urandom_range(1, 255));
            if ($urandom_range(0, 299) == 0)
                sat_mode = ~sat_mode;
            step();
            check_model($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
